// File: rtl/control_seq.sv
// control_seq: EX-stage decoder for the RV32 core with a small sequencer that
// times multi-cycle multiplies, redirect flush bubbles and illegal flagging.
module control_seq #(
  parameter int          MUL_LATENCY   = 3,
  parameter int          FLUSH_CYCLES  = 1,
  parameter bit          ENABLE_M      = 1'b1,
  parameter int          N_GPIO        = 1,
  parameter logic [11:0] CSR_GPIO_BASE = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [11:0]       csr,
  input  logic              branch_taken,
  input  logic              stall_EX,
  output logic              stall_FETCH,
  output logic              alusrc,
  output logic              regwrite,
  output logic [2:0]        regsel,
  output logic [3:0]        aluop,
  output logic [N_GPIO-1:0] gpio_we,
  output logic [1:0]        pcsrc,
  output logic              mul_start,
  output logic              illegal
);

  localparam int MAX_CNT = (MUL_LATENCY > FLUSH_CYCLES) ? MUL_LATENCY : FLUSH_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] MUL_LOAD   = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  typedef enum logic [1:0] {RUN, MUL_WAIT, FLUSH} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [3:0]       alu_f3, mul_code;
  logic             mul_ok, csr_hit, redirect, start_mul;
  logic [12:0]      csr_off;
  logic [N_GPIO-1:0] gpio_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // funct3 mapping shared by R-type and I-type ALU ops, plus the M-extension codes
  always_comb begin
    alu_f3   = 4'b0000;
    mul_code = 4'b0000;
    mul_ok   = 1'b0;
    case (funct3)
      3'b000:  alu_f3 = 4'b0011;
      3'b001:  alu_f3 = 4'b1000;
      3'b010:  alu_f3 = 4'b1100;
      3'b011:  alu_f3 = 4'b1101;
      3'b100:  alu_f3 = 4'b0010;
      3'b101:  alu_f3 = 4'b1001;
      3'b110:  alu_f3 = 4'b0001;
      default: alu_f3 = 4'b0000;
    endcase
    case (funct3)
      3'b000:  begin mul_code = 4'b0101; mul_ok = 1'b1; end
      3'b001:  begin mul_code = 4'b0110; mul_ok = 1'b1; end
      3'b011:  begin mul_code = 4'b0111; mul_ok = 1'b1; end
      default: begin mul_code = 4'b0000; mul_ok = 1'b0; end
    endcase
  end

  assign csr_off = {1'b0, csr} - {1'b0, CSR_GPIO_BASE};
  assign csr_hit = (csr >= CSR_GPIO_BASE) && (csr_off < 13'(N_GPIO));

  always_comb begin
    gpio_onehot = '0;
    for (int i = 0; i < N_GPIO; i++) begin
      if (csr_off == 13'(i)) gpio_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    stall_FETCH = 1'b0;
    alusrc      = 1'b0;
    regwrite    = 1'b0;
    regsel      = 3'd0;
    aluop       = 4'b0000;
    gpio_we     = '0;
    pcsrc       = 2'd0;
    mul_start   = 1'b0;
    illegal     = 1'b0;
    redirect    = 1'b0;
    start_mul   = 1'b0;

    case (state)
      RUN: begin
        case (opcode)
          OP_R: begin
            if (funct7 == 7'b0000000) begin
              regwrite = 1'b1; regsel = 3'd2; aluop = alu_f3;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
              regwrite = 1'b1; regsel = 3'd2; aluop = 4'b0100;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
              regwrite = 1'b1; regsel = 3'd2; aluop = 4'b1010;
            end else if (funct7 == 7'b0000001 && ENABLE_M && mul_ok) begin
              aluop = mul_code; mul_start = 1'b1; stall_FETCH = 1'b1; start_mul = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_I: begin
            if ((funct3 == 3'b001 || funct3 == 3'b101) && funct7 != 7'b0000000) begin
              if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
                alusrc = 1'b1; regwrite = 1'b1; regsel = 3'd2; aluop = 4'b1010;
              end else begin
                illegal = 1'b1;
              end
            end else begin
              alusrc = 1'b1; regwrite = 1'b1; regsel = 3'd2; aluop = alu_f3;
            end
          end
          OP_LUI: begin
            regwrite = 1'b1; regsel = 3'd1;
          end
          OP_JAL: begin
            regwrite = 1'b1; regsel = 3'd3; pcsrc = 2'd1; redirect = 1'b1;
          end
          OP_JALR: begin
            if (funct3 == 3'b000) begin
              regwrite = 1'b1; regsel = 3'd3; alusrc = 1'b1; aluop = 4'b0011;
              pcsrc = 2'd3; redirect = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_BR: begin
            case (funct3)
              3'b000, 3'b001: aluop = 4'b0100;
              3'b100, 3'b101: aluop = 4'b1100;
              3'b110, 3'b111: aluop = 4'b1101;
              default:        illegal = 1'b1;
            endcase
            if (!illegal && branch_taken) begin
              pcsrc = 2'd2; redirect = 1'b1;
            end
          end
          OP_SYS: begin
            if (funct3 == 3'b001 && csr_hit) begin
              gpio_we = gpio_onehot; regwrite = 1'b1; regsel = 3'd0;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase

        if (redirect) begin
          stall_FETCH = 1'b1;
          if (FLUSH_CYCLES > 0) begin
            state_next = FLUSH;
            cnt_next   = FLUSH_LOAD;
          end
        end
        if (start_mul) begin
          state_next = MUL_WAIT;
          cnt_next   = MUL_LOAD;
        end
      end
      MUL_WAIT: begin
        aluop = mul_code;
        if (cnt == '0) begin
          regwrite   = 1'b1;
          regsel     = 3'd4;
          state_next = RUN;
        end else begin
          stall_FETCH = 1'b1;
          cnt_next    = cnt - 1'b1;
        end
      end
      FLUSH: begin
        stall_FETCH = 1'b1;
        if (cnt == '0) state_next = RUN;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = RUN;
    endcase

    // A downstream stall freezes the sequencer and suppresses every side effect
    if (stall_EX) begin
      regwrite   = 1'b0;
      gpio_we    = '0;
      mul_start  = 1'b0;
      state_next = state;
      cnt_next   = cnt;
    end

    if (reset) begin
      stall_FETCH = 1'b0;
      alusrc      = 1'b0;
      regwrite    = 1'b0;
      regsel      = 3'd0;
      aluop       = 4'b0000;
      gpio_we     = '0;
      pcsrc       = 2'd0;
      mul_start   = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed and randomized checks of control_seq against a
// per-instruction timeline model (issue cycle, then wait/flush phases).
module tb_control_seq;

  localparam int          MUL_LAT = 3;
  localparam int          FLUSH_N = 2;
  localparam int          NG      = 4;
  localparam logic [11:0] BASE    = 12'h7C0;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  // Lookup tables indexed by funct3 (element 0 is the rightmost entry)
  localparam logic [7:0][3:0] ALU_F3 = {4'b0000, 4'b0001, 4'b1001, 4'b0010,
                                         4'b1101, 4'b1100, 4'b1000, 4'b0011};
  localparam logic [7:0][3:0] BR_F3  = {4'b1101, 4'b1101, 4'b1100, 4'b1100,
                                         4'b0000, 4'b0000, 4'b0100, 4'b0100};
  localparam logic [7:0]      BR_OK  = 8'b1111_0011;
  localparam logic [7:0][3:0] MUL_F3 = {4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                         4'b0111, 4'b0000, 4'b0110, 4'b0101};
  localparam logic [7:0]      MUL_OK = 8'b0000_1011;

  localparam logic [1:0] K_PLAIN = 2'd0, K_MUL = 2'd1, K_REDIR = 2'd2;

  typedef struct packed {
    logic [17:0] vec;
    logic [1:0]  kind;
  } dec_t;

  logic clk = 1'b0;
  logic reset, branch_taken, stall_EX;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [11:0] csr;

  logic stall_FETCH, alusrc, regwrite, mul_start, illegal;
  logic [2:0] regsel;
  logic [3:0] aluop;
  logic [NG-1:0] gpio_we;
  logic [1:0] pcsrc;

  logic stall_FETCH_n, alusrc_n, regwrite_n, mul_start_n, illegal_n;
  logic [2:0] regsel_n;
  logic [3:0] aluop_n;
  logic [NG-1:0] gpio_we_n;
  logic [1:0] pcsrc_n;

  logic [17:0] obs, obs_nom;
  int n_cmp, n_fail;

  assign obs     = {stall_FETCH, alusrc, regwrite, regsel, aluop, gpio_we, pcsrc, mul_start, illegal};
  assign obs_nom = {stall_FETCH_n, alusrc_n, regwrite_n, regsel_n, aluop_n, gpio_we_n, pcsrc_n,
                    mul_start_n, illegal_n};

  always #5 clk = ~clk;

  control_seq #(.MUL_LATENCY(MUL_LAT), .FLUSH_CYCLES(FLUSH_N), .ENABLE_M(1'b1),
                .N_GPIO(NG), .CSR_GPIO_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7), .csr(csr),
    .branch_taken(branch_taken), .stall_EX(stall_EX), .stall_FETCH(stall_FETCH),
    .alusrc(alusrc), .regwrite(regwrite), .regsel(regsel), .aluop(aluop), .gpio_we(gpio_we),
    .pcsrc(pcsrc), .mul_start(mul_start), .illegal(illegal));

  control_seq #(.MUL_LATENCY(MUL_LAT), .FLUSH_CYCLES(FLUSH_N), .ENABLE_M(1'b0),
                .N_GPIO(NG), .CSR_GPIO_BASE(BASE)) dut_nom (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7), .csr(csr),
    .branch_taken(branch_taken), .stall_EX(stall_EX), .stall_FETCH(stall_FETCH_n),
    .alusrc(alusrc_n), .regwrite(regwrite_n), .regsel(regsel_n), .aluop(aluop_n),
    .gpio_we(gpio_we_n), .pcsrc(pcsrc_n), .mul_start(mul_start_n), .illegal(illegal_n));

  function automatic logic [17:0] mk(input int sf, input int as, input int rw, input int rs,
                                     input int op, input int g, input int pc, input int ms,
                                     input int il);
    return {1'(sf), 1'(as), 1'(rw), 3'(rs), 4'(op), 4'(g), 2'(pc), 1'(ms), 1'(il)};
  endfunction

  function automatic dec_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [11:0] c,
                                      input logic tk, input bit m_en);
    dec_t d;
    int off;
    d.kind = K_PLAIN;
    d.vec  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    case (op)
      OP_R: begin
        if (f7 == 7'd0)                         d.vec = mk(0, 0, 1, 2, int'(ALU_F3[f3]), 0, 0, 0, 0);
        else if (f7 == 7'b0100000 && f3 == 3'd0) d.vec = mk(0, 0, 1, 2, 'b0100, 0, 0, 0, 0);
        else if (f7 == 7'b0100000 && f3 == 3'd5) d.vec = mk(0, 0, 1, 2, 'b1010, 0, 0, 0, 0);
        else if (f7 == 7'b0000001 && m_en && MUL_OK[f3]) begin
          d.vec  = mk(1, 0, 0, 0, int'(MUL_F3[f3]), 0, 0, 1, 0);
          d.kind = K_MUL;
        end
      end
      OP_I: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (f7 == 7'd0)                          d.vec = mk(0, 1, 1, 2, int'(ALU_F3[f3]), 0, 0, 0, 0);
          else if (f3 == 3'd5 && f7 == 7'b0100000) d.vec = mk(0, 1, 1, 2, 'b1010, 0, 0, 0, 0);
        end else begin
          d.vec = mk(0, 1, 1, 2, int'(ALU_F3[f3]), 0, 0, 0, 0);
        end
      end
      OP_LUI: d.vec = mk(0, 0, 1, 1, 0, 0, 0, 0, 0);
      OP_JAL: begin d.vec = mk(1, 0, 1, 3, 0, 0, 1, 0, 0); d.kind = K_REDIR; end
      OP_JALR: if (f3 == 3'd0) begin d.vec = mk(1, 1, 1, 3, 'b0011, 0, 3, 0, 0); d.kind = K_REDIR; end
      OP_BR: if (BR_OK[f3]) begin
        if (tk) begin d.vec = mk(1, 0, 0, 0, int'(BR_F3[f3]), 0, 2, 0, 0); d.kind = K_REDIR; end
        else    d.vec = mk(0, 0, 0, 0, int'(BR_F3[f3]), 0, 0, 0, 0);
      end
      OP_SYS: begin
        off = int'(c) - int'(BASE);
        if (f3 == 3'd1 && off >= 0 && off < NG) d.vec = mk(0, 0, 1, 0, 0, 1 << off, 0, 0, 0);
      end
      default: ;
    endcase
    return d;
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [11:0] c, input logic tk);
    opcode = op; funct3 = f3; funct7 = f7; csr = c; branch_taken = tk;
  endtask

  task automatic gen_instr(output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7,
                           output logic [11:0] c, output logic tk);
    int cls;
    cls = int'($urandom_range(0, 8));
    f3 = 3'($urandom_range(0, 7));
    f7 = 7'($urandom);
    c  = 12'($urandom);
    tk = 1'($urandom);
    case (cls)
      0: begin op = OP_R; f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0; end
      1: begin
        op = OP_I;
        if (f3 == 3'd1) f7 = 7'd0;
        else if (f3 == 3'd5) f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0;
      end
      2: op = OP_LUI;
      3: op = OP_JAL;
      4: begin op = OP_JALR; if ($urandom_range(0, 3) != 0) f3 = 3'd0; end
      5: op = OP_BR;
      6: begin
        op = OP_SYS;
        if ($urandom_range(0, 3) != 0) f3 = 3'd1;
        c = BASE - 12'd1 + 12'($urandom_range(0, 6));
      end
      7: begin op = OP_R; f7 = 7'b0000001; end
      default: op = 7'($urandom);
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_instr(OP_R, 3'd0, 7'd0, 12'h0, 1'b0); #4;
    n_cmp++; if (obs !== '0) begin n_fail++; $display("[TB] FAIL reset_add: got %b want %b", obs, 18'd0); end
    n_cmp++; if (obs_nom !== '0) begin n_fail++; $display("[TB] FAIL reset_nom: got %b want %b", obs_nom, 18'd0); end
    @(posedge clk); #1;
    set_instr(OP_R, 3'd0, 7'b0000001, 12'h0, 1'b1); #4;
    n_cmp++; if (obs !== '0) begin n_fail++; $display("[TB] FAIL reset_mul: got %b want %b", obs, 18'd0); end
    @(posedge clk); #1;
    reset = 1'b0;
    set_instr(OP_R, 3'd0, 7'd0, 12'h0, 1'b0); #4;
    n_cmp++; if (obs !== mk(0, 0, 1, 2, 'b0011, 0, 0, 0, 0))
      begin n_fail++; $display("[TB] FAIL post_reset_add: got %b want %b", obs, mk(0, 0, 1, 2, 'b0011, 0, 0, 0, 0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [17:0] e;
    set_instr(OP_R, 3'd0, 7'b0000001, 12'h0, 1'b0); #4;
    e = mk(1, 0, 0, 0, 'b0101, 0, 0, 1, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL mul_issue: got %b want %b", obs, e); end
    for (int k = 1; k < MUL_LAT; k++) begin
      @(posedge clk); #5;
      e = mk(1, 0, 0, 0, 'b0101, 0, 0, 0, 0);
      n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL mul_wait%0d: got %b want %b", k, obs, e); end
    end
    @(posedge clk); #5;
    e = mk(0, 0, 1, 4, 'b0101, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL mul_writeback: got %b want %b", obs, e); end
    @(posedge clk); #1;
    set_instr(OP_R, 3'd0, 7'd0, 12'h0, 1'b0); #4;
    e = mk(0, 0, 1, 2, 'b0011, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL mul_then_add: got %b want %b", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_branch_flush();
    logic [17:0] e;
    set_instr(OP_BR, 3'd0, 7'd0, 12'h0, 1'b1); #4;
    e = mk(1, 0, 0, 0, 'b0100, 0, 2, 0, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL beq_taken: got %b want %b", obs, e); end
    @(posedge clk); #1;
    set_instr(OP_R, 3'd0, 7'd0, 12'h0, 1'b0);
    for (int k = 1; k <= FLUSH_N; k++) begin
      #4;
      e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL flush%0d: got %b want %b", k, obs, e); end
      @(posedge clk); #1;
    end
    #4;
    e = mk(0, 0, 1, 2, 'b0011, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL flush_resume: got %b want %b", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_gpio();
    logic [11:0] addr [5] = '{12'h7C2, 12'h7C4, 12'h7C0, 12'h7C3, 12'h7BF};
    logic [17:0] want [5];
    want[0] = mk(0, 0, 1, 0, 0, 'b0100, 0, 0, 0);
    want[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    want[2] = mk(0, 0, 1, 0, 0, 'b0001, 0, 0, 0);
    want[3] = mk(0, 0, 1, 0, 0, 'b1000, 0, 0, 0);
    want[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      set_instr(OP_SYS, 3'd1, 7'd0, addr[i], 1'b0); #4;
      n_cmp++; if (obs !== want[i]) begin n_fail++; $display("[TB] FAIL gpio_%h: got %b want %b", addr[i], obs, want[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shifts();
    logic [17:0] e;
    set_instr(OP_I, 3'd5, 7'b0100000, 12'h0, 1'b0); #4;
    e = mk(0, 1, 1, 2, 'b1010, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL srai: got %b want %b", obs, e); end
    @(posedge clk); #1;
    set_instr(OP_I, 3'd5, 7'd0, 12'h0, 1'b0); #4;
    e = mk(0, 1, 1, 2, 'b1001, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL srli: got %b want %b", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_no_m();
    logic [17:0] e;
    set_instr(OP_R, 3'd1, 7'b0000001, 12'h0, 1'b0); #4;
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (obs_nom !== e) begin n_fail++; $display("[TB] FAIL nom_mulh: got %b want %b", obs_nom, e); end
    e = mk(1, 0, 0, 0, 'b0110, 0, 0, 1, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL mulh_issue: got %b want %b", obs, e); end
    repeat (MUL_LAT) @(posedge clk);
    #5;
    e = mk(0, 0, 1, 4, 'b0110, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL mulh_writeback: got %b want %b", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_mul();
    logic [17:0] e;
    set_instr(OP_R, 3'd3, 7'b0000001, 12'h0, 1'b0);
    stall_EX = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #4;
      e = mk(1, 0, 0, 0, 'b0111, 0, 0, 0, 0);
      n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL stalled_issue%0d: got %b want %b", k, obs, e); end
      @(posedge clk); #1;
    end
    stall_EX = 1'b0; #4;
    e = mk(1, 0, 0, 0, 'b0111, 0, 0, 1, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL delayed_issue: got %b want %b", obs, e); end
    repeat (MUL_LAT) @(posedge clk);
    #1; stall_EX = 1'b1; #4;
    e = mk(0, 0, 0, 4, 'b0111, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL stalled_writeback: got %b want %b", obs, e); end
    @(posedge clk); #1;
    stall_EX = 1'b0; #4;
    e = mk(0, 0, 1, 4, 'b0111, 0, 0, 0, 0);
    n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL late_writeback: got %b want %b", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mul_wait();
    logic [17:0] e;
    set_instr(OP_R, 3'd0, 7'b0000001, 12'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; #4;
    n_cmp++; if (obs !== '0) begin n_fail++; $display("[TB] FAIL reset_in_wait: got %b want %b", obs, 18'd0); end
    @(posedge clk); #1;
    reset = 1'b0;
    set_instr(OP_BR, 3'd0, 7'd0, 12'h0, 1'b0);
    for (int k = 0; k <= MUL_LAT; k++) begin
      #4;
      e = mk(0, 0, 0, 0, 'b0100, 0, 0, 0, 0);
      n_cmp++; if (obs !== e) begin n_fail++; $display("[TB] FAIL after_abort%0d: got %b want %b", k, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    dec_t d;
    logic [17:0] e, keep;
    logic [17:0] q[$];
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [11:0] c;
    logic tk;
    int run;
    keep = ~mk(0, 0, 1, 0, 0, 'hF, 0, 1, 0);
    for (int n = 0; n < 400; n++) begin
      gen_instr(op, f3, f7, c, tk);
      set_instr(op, f3, f7, c, tk);
      d = ref_decode(op, f3, f7, c, tk, 1'b1);
      q.delete();
      q.push_back(d.vec);
      if (d.kind == K_MUL) begin
        for (int k = 1; k < MUL_LAT; k++) q.push_back(mk(1, 0, 0, 0, int'(MUL_F3[f3]), 0, 0, 0, 0));
        q.push_back(mk(0, 0, 1, 4, int'(MUL_F3[f3]), 0, 0, 0, 0));
      end else if (d.kind == K_REDIR) begin
        for (int k = 0; k < FLUSH_N; k++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      run = 0;
      while (q.size() > 0) begin
        stall_EX = (run < 3) && ($urandom_range(0, 3) == 0);
        #4;
        e = stall_EX ? (q[0] & keep) : q[0];
        n_cmp++;
        if (obs !== e) begin
          n_fail++;
          $display("[TB] FAIL rand%0d op=%b f3=%b f7=%b: got %b want %b", n, op, f3, f7, obs, e);
        end
        @(posedge clk); #1;
        if (stall_EX) run++;
        else begin
          run = 0;
          void'(q.pop_front());
          if (d.kind == K_REDIR) begin
            gen_instr(op, f3, f7, c, tk);
            set_instr(op, f3, f7, c, tk);
          end
        end
      end
      stall_EX = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    stall_EX = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0, 12'h0, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_mul();
    test_branch_flush();
    test_gpio();
    test_shifts();
    test_no_m();
    test_stall_mul();
    test_reset_mul_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_seq.md
# control_seq

Sequential, parametrised control unit for the single-issue RV32 core. It decodes the EX-stage instruction fields into datapath controls, as the combinational decoder did. It adds a small FSM for multi-cycle multiplies, branch/jump flush sequencing and illegal-instruction flagging. GPIO CSRs generalise to N one-hot write-enabled channels.

## Interface
- `MUL_LATENCY`, default 3: cycles from `mul_start` to multiplier result valid; legal range ≥1.
- `FLUSH_CYCLES`, default 1: bubble cycles after a redirect; legal range ≥0.
- `ENABLE_M`, default 1: when 0, mul/mulh/mulhu decode as illegal.
- `N_GPIO`, default 1: GPIO output channels; legal range 1..16.
- `CSR_GPIO_BASE`, default 12'h000: CSR address of GPIO channel 0.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7, `funct3` in 3, `funct7` in 7, `csr` in 12: EX-stage instruction fields.
- `branch_taken` in 1: ALU compare result for the current branch, valid in the same cycle.
- `stall_EX` in 1: EX held by downstream logic.
- `stall_FETCH` out 1: hold or kill the fetch stage.
- `alusrc` out 1: 0 = rs2, 1 = immediate.
- `regwrite` out 1: register-file write enable.
- `regsel` out 3: write-data select. 0 = GPIO/CSR read, 1 = imm_U, 2 = ALU, 3 = PC+4, 4 = multiplier result.
- `aluop` out 4: ALU operation code.
- `gpio_we` out N_GPIO: one-hot GPIO channel write enable.
- `pcsrc` out 2: next-PC select. 0 = PC+4, 1 = jal target, 2 = branch target, 3 = jalr target.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `illegal` out 1: current instruction is not supported.

## Operation
- FSM states: RUN, MUL_WAIT, FLUSH. A down-counter `cnt` (≥ clog2 of max(MUL_LATENCY, FLUSH_CYCLES)+1 bits) times MUL_WAIT and FLUSH.
- Default outputs are all 0. Outputs are combinational from the inputs plus the registered state.

Decode in RUN:
- R-type (0110011):
  - add 0011, and 0000, or 0001, xor 0010, sll 1000, srl 1001, slt 1100, sltu 1101.
  - sub 0100, sra 1010 (funct7 0100000).
  - All of the above set regwrite=1, regsel=2.
- I-type (0010011): alusrc=1, regwrite=1, regsel=2, aluop as for R-type.
  - funct3 101 selects srli when funct7=0000000 and srai when funct7=0100000.
- lui (0110111): regwrite=1, regsel=1.
- jal (1101111): regwrite=1, regsel=3, pcsrc=1. Enters the redirect sequence.
- jalr (1100111, funct3 000): regwrite=1, regsel=3, alusrc=1, aluop=0011, pcsrc=3. Enters the redirect sequence.
- Branch (1100011):
  - aluop by funct3: beq/bne 0100, blt/bge 1100, bltu/bgeu 1101.
  - If `branch_taken`=1: pcsrc=2 and enter the redirect sequence. Otherwise no other effect.
  - funct3 010/011 decode as illegal.
- csrrw (1110011, funct3 001) with `csr` in [CSR_GPIO_BASE, CSR_GPIO_BASE+N_GPIO):
  - gpio_we bit (csr−CSR_GPIO_BASE)=1, regwrite=1, regsel=0.
  - Any other CSR address is illegal.
- M ops (funct7 0000001; mul 0101, mulh 0110, mulhu 0111; ENABLE_M=1):
  - aluop set, mul_start=1, stall_FETCH=1, regwrite=0.
  - Load cnt=MUL_LATENCY−1, go to MUL_WAIT.
- Any other encoding: illegal=1, and regwrite, gpio_we, mul_start and pcsrc all stay 0.

Redirect sequence:
- In the decode cycle: stall_FETCH=1.
- If FLUSH_CYCLES>0: load cnt=FLUSH_CYCLES−1 and go to FLUSH. Otherwise stay in RUN.

MUL_WAIT:
- stall_FETCH=1, all write enables 0, aluop holds the M code.
- When cnt=0: regwrite=1, regsel=4, stall_FETCH=0, go to RUN.
- Otherwise decrement cnt.
- The instruction fields are guaranteed stable during this state, because fetch is stalled.

FLUSH:
- stall_FETCH=1. All write enables, mul_start, illegal and pcsrc are 0; the inputs are ignored.
- When cnt=0, go to RUN. Otherwise decrement cnt.

`stall_EX`=1 overrides everything:
- regwrite, gpio_we and mul_start are forced to 0.
- State and cnt hold.
- Other outputs keep their decoded values.

## Timing
- Reset:
  - While `reset`=1, every output is 0.
  - The next state is RUN with cnt=0.
  - Reset during MUL_WAIT or FLUSH abandons the operation; there is no write-back.
- Plain ops have zero latency: controls are valid in the same cycle the fields are presented.
- Multiply issued at cycle T (no stalls):
  - mul_start is high at T only.
  - stall_FETCH is high from T to T+MUL_LATENCY−1.
  - regwrite with regsel=4 occurs at T+MUL_LATENCY.
  - The state is RUN again at T+MUL_LATENCY+1.
  - Each stall_EX cycle adds one cycle.
- Redirect at cycle T: stall_FETCH is high from T to T+FLUSH_CYCLES, and decode resumes at T+FLUSH_CYCLES+1.
- A stall_EX assertion in the cycle of a multiply issue delays mul_start until the first cycle with stall_EX=0.

## Test plan
- Reset then add (opcode 0110011, f3 000, f7 0): all outputs 0 during reset. The next cycle gives regwrite=1, regsel=2, aluop=0011, stall_FETCH=0.
- mul, MUL_LATENCY=3, at T: mul_start=1 at T only; stall_FETCH=1 for T..T+2; regwrite=1 with regsel=4 at T+3; a following add decodes at T+4.
- Taken beq, FLUSH_CYCLES=2, at T: pcsrc=2 and stall_FETCH=1 at T. At T+1 and T+2, an add presented on the inputs produces regwrite=0. Normal decode at T+3.
- N_GPIO=4, base 12'h7C0, csrrw with csr=12'h7C2: gpio_we=4'b0100, regwrite=1. csr=12'h7C4: illegal=1, gpio_we=0.
- srai (f3 101, f7 0100000): aluop=1010. srli (f7 0): aluop=1001. ENABLE_M=0 with mul: illegal=1, mul_start=0.
- Reset asserted during MUL_WAIT: no regwrite in any later cycle, and the next cycle after reset decodes in RUN.
